// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses, mstatus
// bit positions, cause codes, FSM encoding and the mstatus update rules.
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    localparam logic [3:0]  EXC_ILLEGAL = 4'd2;
    localparam logic [3:0]  EXC_BREAK   = 4'd3;
    localparam logic [3:0]  EXC_ECALL_M = 4'd11;
    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_MEPC    = 3'd1,
        ST_W_MCAUSE  = 3'd2,
        ST_W_MSTATUS = 3'd3,
        ST_R_MSTATUS = 3'd4,
        ST_JUMP      = 3'd5
    } state_t;

    // Trap entry: stash MIE in MPIE, mask interrupts, record M as previous mode.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE] = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MIE] = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer: writes mepc/mcause/mstatus through the shared
// CSR write port, then flushes and redirects fetch; otherwise passes execute's writes.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int CSR_AW          = 12,
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic              exc_valid,
    input  logic [3:0]        exc_cause,
    input  logic              mret_valid,
    input  logic              irq_ext,
    input  logic              irq_timer,
    input  logic [DATA_W-1:0] csr_mstatus,
    input  logic [DATA_W-1:0] csr_mie,
    input  logic [DATA_W-1:0] csr_mtvec,
    input  logic [DATA_W-1:0] csr_mepc,
    input  logic              ex_csr_we,
    input  logic [CSR_AW-1:0] ex_csr_waddr,
    input  logic [DATA_W-1:0] ex_csr_wdata,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [DATA_W-1:0] csr_wdata,
    output logic              stall,
    output logic              flush,
    output logic [DATA_W-1:0] redirect_pc
);

    generate
        if (RESET_PC_UNUSED != 0 || DATA_W != 32 || CSR_AW != 12) begin : g_bad_param
            $error("trap_ctrl supports only DATA_W=32, CSR_AW=12, RESET_PC_UNUSED=0");
        end
    endgenerate

    state_t              state_reg, state_next;
    logic [DATA_W-1:2]   epc_reg, epc_next;
    logic [DATA_W-1:0]   cause_reg, cause_next;
    logic [DATA_W-1:0]   mstatus_reg, mstatus_next;
    logic                mret_reg, mret_next;

    logic                take_ext, take_timer, take_trap;
    logic [DATA_W-1:0]   trap_cause;
    logic [DATA_W-1:0]   vec_base;
    logic                we_c, stall_c, flush_c;
    logic [CSR_AW-1:0]   waddr_c;
    logic [DATA_W-1:0]   wdata_c, rpc_c;

    assign take_ext   = irq_ext & csr_mstatus[MSTATUS_MIE] & csr_mie[MIE_MEIE];
    assign take_timer = irq_timer & csr_mstatus[MSTATUS_MIE] & csr_mie[MIE_MTIE];
    assign take_trap  = exc_valid | take_ext | take_timer;

    always_comb begin
        trap_cause = CAUSE_TIMER;
        if (exc_valid)
            trap_cause = {{(DATA_W-4){1'b0}}, exc_cause};
        else if (take_ext)
            trap_cause = CAUSE_EXT;
    end

    assign vec_base = {csr_mtvec[DATA_W-1:2], 2'b00};

    always_comb begin
        state_next   = state_reg;
        epc_next     = epc_reg;
        cause_next   = cause_reg;
        mstatus_next = mstatus_reg;
        mret_next    = mret_reg;
        we_c         = 1'b0;
        waddr_c      = '0;
        wdata_c      = '0;
        stall_c      = 1'b0;
        flush_c      = 1'b0;
        rpc_c        = '0;
        case (state_reg)
            ST_IDLE: begin
                if (take_trap) begin
                    stall_c      = 1'b1;
                    epc_next     = ex_pc[DATA_W-1:2];
                    cause_next   = trap_cause;
                    mstatus_next = csr_mstatus;
                    mret_next    = 1'b0;
                    state_next   = ST_W_MEPC;
                end else if (mret_valid) begin
                    stall_c      = 1'b1;
                    mstatus_next = csr_mstatus;
                    mret_next    = 1'b1;
                    state_next   = ST_R_MSTATUS;
                end else if (ex_csr_we) begin
                    we_c    = 1'b1;
                    waddr_c = ex_csr_waddr;
                    wdata_c = ex_csr_wdata;
                end
            end
            ST_W_MEPC: begin
                stall_c    = 1'b1;
                we_c       = 1'b1;
                waddr_c    = CSR_MEPC;
                wdata_c    = {epc_reg, 2'b00};
                state_next = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
                stall_c    = 1'b1;
                we_c       = 1'b1;
                waddr_c    = CSR_MCAUSE;
                wdata_c    = cause_reg;
                state_next = ST_W_MSTATUS;
            end
            ST_W_MSTATUS: begin
                stall_c    = 1'b1;
                we_c       = 1'b1;
                waddr_c    = CSR_MSTATUS;
                wdata_c    = trap_mstatus(mstatus_reg);
                state_next = ST_JUMP;
            end
            ST_R_MSTATUS: begin
                stall_c    = 1'b1;
                we_c       = 1'b1;
                waddr_c    = CSR_MSTATUS;
                wdata_c    = mret_mstatus(mstatus_reg);
                state_next = ST_JUMP;
            end
            ST_JUMP: begin
                stall_c    = 1'b1;
                flush_c    = 1'b1;
                state_next = ST_IDLE;
                // mepc is read live here so an mret sees whatever the CSR file now holds
                if (mret_reg)
                    rpc_c = csr_mepc;
                else if (csr_mtvec[1:0] == 2'b01 && cause_reg[DATA_W-1])
                    rpc_c = vec_base + {{(DATA_W-6){1'b0}}, cause_reg[3:0], 2'b00};
                else
                    rpc_c = vec_base;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            epc_reg     <= '0;
            cause_reg   <= '0;
            mstatus_reg <= '0;
            mret_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            epc_reg     <= epc_next;
            cause_reg   <= cause_next;
            mstatus_reg <= mstatus_next;
            mret_reg    <= mret_next;
        end
    end

    // Reset forces the port quiet even while execute is still presenting a write.
    assign csr_we      = we_c & ~rst;
    assign csr_waddr   = rst ? '0 : waddr_c;
    assign csr_wdata   = rst ? '0 : wdata_c;
    assign stall       = stall_c & ~rst;
    assign flush       = flush_c & ~rst;
    assign redirect_pc = rst ? '0 : rpc_c;

    logic unused_bits;
    assign unused_bits = ^{ex_pc[1:0], csr_mie, cause_reg[DATA_W-2:4]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: vector table, directed multi-cycle sequences
// and a randomized run against a script-queue reference model.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_pc;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic        mret_valid;
    logic        irq_ext;
    logic        irq_timer;
    logic [31:0] csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
    logic        ex_csr_we;
    logic [11:0] ex_csr_waddr;
    logic [31:0] ex_csr_wdata;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        stall, flush;
    logic [31:0] redirect_pc;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk(clk), .rst(rst), .ex_pc(ex_pc), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .mret_valid(mret_valid), .irq_ext(irq_ext), .irq_timer(irq_timer),
        .csr_mstatus(csr_mstatus), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .ex_csr_we(ex_csr_we), .ex_csr_waddr(ex_csr_waddr), .ex_csr_wdata(ex_csr_wdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .stall(stall), .flush(flush), .redirect_pc(redirect_pc)
    );

    // ---------------- checking helpers ----------------
    task automatic cmp(input string nm, input logic we, input logic [11:0] a, input logic [31:0] d,
                       input logic st, input logic fl, input logic [31:0] rp);
        bit ok;
        ok = (csr_we === we) && (csr_waddr === a) && (stall === st) && (flush === fl);
        if (we) ok = ok && (csr_wdata === d);
        if (fl) ok = ok && (redirect_pc === rp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got we=%0b addr=%h data=%h stall=%0b flush=%0b pc=%h; want we=%0b addr=%h data=%h stall=%0b flush=%0b pc=%h",
                      nm, csr_we, csr_waddr, csr_wdata, stall, flush, redirect_pc, we, a, d, st, fl, rp);
    endtask

    task automatic chk(input string nm, input logic we, input logic [11:0] a, input logic [31:0] d,
                       input logic st, input logic fl, input logic [31:0] rp);
        @(negedge clk);
        cmp(nm, we, a, d, st, fl, rp);
    endtask

    task automatic chk_zero(input string nm);
        total_cnt++;
        if ({csr_we, csr_waddr, csr_wdata, stall, flush, redirect_pc} === '0) pass_cnt++;
        else $display("FAIL %s: got we=%0b addr=%h data=%h stall=%0b flush=%0b pc=%h; want all zero",
                      nm, csr_we, csr_waddr, csr_wdata, stall, flush, redirect_pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_pc = 0; exc_valid = 0; exc_cause = 0; mret_valid = 0; irq_ext = 0; irq_timer = 0;
        csr_mstatus = 0; csr_mie = 0; csr_mtvec = 0; csr_mepc = 0;
        ex_csr_we = 0; ex_csr_waddr = 0; ex_csr_wdata = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          kind;    // 0 stall-only, 1 CSR write, 2 jump
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] cause;
        bit          is_mret;
    } step_t;

    step_t script[$];

    function automatic logic [31:0] ms_after_trap(input logic [31:0] ms);
        return (ms & ~32'h0000_1888) | (((ms >> 3) & 32'd1) << 7) | 32'h0000_1800;
    endfunction

    function automatic logic [31:0] ms_after_mret(input logic [31:0] ms);
        return (ms & ~32'h0000_1888) | (((ms >> 7) & 32'd1) << 3) | 32'h0000_1880;
    endfunction

    function automatic step_t mk(input int k, input logic [11:0] a, input logic [31:0] d,
                                 input logic [31:0] c, input bit m);
        step_t s;
        s.kind = k; s.addr = a; s.data = d; s.cause = c; s.is_mret = m;
        return s;
    endfunction

    task automatic push_trap(input logic [31:0] c);
        script.push_back(mk(0, 12'h0, 0, 0, 0));
        script.push_back(mk(1, 12'h341, ex_pc & 32'hFFFF_FFFC, 0, 0));
        script.push_back(mk(1, 12'h342, c, 0, 0));
        script.push_back(mk(1, 12'h300, ms_after_trap(csr_mstatus), 0, 0));
        script.push_back(mk(2, 12'h0, 0, c, 0));
    endtask

    task automatic model_check(input string nm);
        step_t s;
        logic [31:0] rp;
        if (script.size() == 0) begin
            if (exc_valid) push_trap(32'(exc_cause));
            else if (irq_ext && csr_mstatus[3] && csr_mie[11]) push_trap(32'h8000_000B);
            else if (irq_timer && csr_mstatus[3] && csr_mie[7]) push_trap(32'h8000_0007);
            else if (mret_valid) begin
                script.push_back(mk(0, 12'h0, 0, 0, 1));
                script.push_back(mk(1, 12'h300, ms_after_mret(csr_mstatus), 0, 1));
                script.push_back(mk(2, 12'h0, 0, 0, 1));
            end
        end
        if (script.size() == 0) begin
            cmp(nm, ex_csr_we, ex_csr_we ? ex_csr_waddr : 12'h0, ex_csr_wdata, 0, 0, 0);
        end else begin
            s = script.pop_front();
            if (s.kind == 0) cmp(nm, 0, 0, 0, 1, 0, 0);
            else if (s.kind == 1) cmp(nm, 1, s.addr, s.data, 1, 0, 0);
            else begin
                if (s.is_mret) rp = csr_mepc;
                else begin
                    rp = csr_mtvec & 32'hFFFF_FFFC;
                    if (csr_mtvec[1:0] == 2'b01 && s.cause[31]) rp = rp + (s.cause % 16) * 4;
                end
                cmp(nm, 0, 0, 0, 1, 1, rp);
            end
        end
    endtask

    // ---------------- accept-cycle vector table ----------------
    typedef struct {
        string       nm;
        logic        exc, mret, ext, tmr, ex_we;
        logic [31:0] ms, mie;
        logic [11:0] ex_a;
        logic [31:0] ex_d;
        logic        e_st, e_we;
        logic [11:0] e_a;
        logic [31:0] e_d;
    } vec_t;

    vec_t vecs[8];

    initial begin
        rst = 1'b1;
        clear_inputs();
        #2;
        chk_zero("reset_async");
        tick();
        rst = 1'b0;
        chk("reset_idle", 0, 0, 0, 0, 0, 0);

        //            nm           exc mret ext tmr we  ms     mie    ex_a    ex_d           st we e_a     e_d
        vecs[0] = '{"pass_mtvec", 0, 0, 0, 0, 1, 32'h0, 32'h0, 12'h305, 32'hDEAD_0000, 0, 1, 12'h305, 32'hDEAD_0000};
        vecs[1] = '{"pass_none",  0, 0, 0, 0, 0, 32'h8, 32'h0, 12'h123, 32'h1111_2222, 0, 0, 12'h000, 32'h0};
        vecs[2] = '{"tmr_mie0",   0, 0, 0, 1, 1, 32'h0, 32'h80, 12'h340, 32'h0000_5555, 0, 1, 12'h340, 32'h0000_5555};
        vecs[3] = '{"tmr_accept", 0, 0, 0, 1, 1, 32'h8, 32'h80, 12'h340, 32'h0000_5555, 1, 0, 12'h000, 32'h0};
        vecs[4] = '{"ext_mie0",   0, 0, 1, 0, 1, 32'h0, 32'h800, 12'h304, 32'h0000_0888, 0, 1, 12'h304, 32'h0000_0888};
        vecs[5] = '{"exc_supp",   1, 0, 0, 0, 1, 32'h0, 32'h0, 12'h305, 32'hDEAD_0000, 1, 0, 12'h000, 32'h0};
        vecs[6] = '{"mret_supp",  0, 1, 0, 0, 1, 32'h0, 32'h0, 12'h305, 32'hDEAD_0000, 1, 0, 12'h000, 32'h0};
        vecs[7] = '{"ext_meie0",  0, 0, 1, 0, 0, 32'h8, 32'h80, 12'h000, 32'h0, 0, 0, 12'h000, 32'h0};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            exc_valid = vecs[i].exc; exc_cause = 4'd11; mret_valid = vecs[i].mret;
            irq_ext = vecs[i].ext; irq_timer = vecs[i].tmr;
            csr_mstatus = vecs[i].ms; csr_mie = vecs[i].mie;
            ex_csr_we = vecs[i].ex_we; ex_csr_waddr = vecs[i].ex_a; ex_csr_wdata = vecs[i].ex_d;
            chk(vecs[i].nm, vecs[i].e_we, vecs[i].e_a, vecs[i].e_d, vecs[i].e_st, 0, 0);
        end

        // ecall, direct mtvec
        do_reset();
        ex_pc = 32'h124; exc_valid = 1; exc_cause = 4'd11; csr_mtvec = 32'h200; csr_mstatus = 32'h8;
        chk("ecall_c1", 0, 0, 0, 1, 0, 0); tick(); exc_valid = 0;
        chk("ecall_mepc", 1, 12'h341, 32'h124, 1, 0, 0); tick();
        chk("ecall_mcause", 1, 12'h342, 32'hB, 1, 0, 0); tick();
        chk("ecall_mstatus", 1, 12'h300, 32'h1880, 1, 0, 0); tick();
        chk("ecall_jump", 0, 0, 0, 1, 1, 32'h200); tick();
        chk("ecall_idle", 0, 0, 0, 0, 0, 0);

        // vectored timer, irq held through the sequence
        do_reset();
        ex_pc = 32'h88; irq_timer = 1; csr_mtvec = 32'h201; csr_mie = 32'h80; csr_mstatus = 32'h8;
        chk("vt_c1", 0, 0, 0, 1, 0, 0); tick();
        chk("vt_mepc", 1, 12'h341, 32'h88, 1, 0, 0); tick();
        chk("vt_mcause", 1, 12'h342, 32'h8000_0007, 1, 0, 0); tick();
        chk("vt_mstatus", 1, 12'h300, 32'h1880, 1, 0, 0); tick();
        irq_timer = 0;
        chk("vt_jump", 0, 0, 0, 1, 1, 32'h21C); tick();
        chk("vt_idle", 0, 0, 0, 0, 0, 0);

        // mret
        do_reset();
        mret_valid = 1; csr_mstatus = 32'h1880; csr_mepc = 32'h128;
        chk("mret_c1", 0, 0, 0, 1, 0, 0); tick(); mret_valid = 0;
        chk("mret_mstatus", 1, 12'h300, 32'h1888, 1, 0, 0); tick();
        chk("mret_jump", 0, 0, 0, 1, 1, 32'h128); tick();
        chk("mret_idle", 0, 0, 0, 0, 0, 0);

        // exception beats an enabled external interrupt
        do_reset();
        ex_pc = 32'h40; exc_valid = 1; exc_cause = 4'd2; irq_ext = 1; csr_mie = 32'h800;
        csr_mstatus = 32'h8; csr_mtvec = 32'h100;
        chk("prio_c1", 0, 0, 0, 1, 0, 0); tick(); exc_valid = 0; irq_ext = 0;
        chk("prio_mepc", 1, 12'h341, 32'h40, 1, 0, 0); tick();
        chk("prio_mcause", 1, 12'h342, 32'h2, 1, 0, 0); tick();
        chk("prio_mstatus", 1, 12'h300, 32'h1880, 1, 0, 0); tick();
        chk("prio_jump", 0, 0, 0, 1, 1, 32'h100); tick();

        // reset in W_MCAUSE
        do_reset();
        ex_pc = 32'h500; exc_valid = 1; exc_cause = 4'd3; csr_mtvec = 32'h100; csr_mstatus = 32'h8;
        chk("rstseq_c1", 0, 0, 0, 1, 0, 0); tick(); exc_valid = 0;
        chk("rstseq_mepc", 1, 12'h341, 32'h500, 1, 0, 0); tick();
        ex_csr_we = 1; ex_csr_waddr = 12'h305; ex_csr_wdata = 32'hDEAD_0000;
        chk("rstseq_mcause", 1, 12'h342, 32'h3, 1, 0, 0);
        #1 rst = 1'b1;
        #1 chk_zero("rstseq_async");
        tick(); rst = 1'b0; ex_csr_we = 0;
        chk("rstseq_idle", 0, 0, 0, 0, 0, 0); tick();
        chk("rstseq_idle2", 0, 0, 0, 0, 0, 0);

        // back-to-back exceptions, external irq deferred until IDLE
        do_reset();
        ex_pc = 32'h300; exc_valid = 1; exc_cause = 4'd3; csr_mtvec = 32'h400;
        csr_mstatus = 32'h8; csr_mie = 32'h800;
        chk("b2b_c1", 0, 0, 0, 1, 0, 0); tick();
        chk("b2b_mepc1", 1, 12'h341, 32'h300, 1, 0, 0); tick(); irq_ext = 1;
        chk("b2b_mcause1", 1, 12'h342, 32'h3, 1, 0, 0); tick();
        chk("b2b_ms1", 1, 12'h300, 32'h1880, 1, 0, 0); tick(); ex_pc = 32'h304;
        chk("b2b_jump1", 0, 0, 0, 1, 1, 32'h400); tick();
        chk("b2b_c6", 0, 0, 0, 1, 0, 0); tick(); exc_valid = 0;
        chk("b2b_mepc2", 1, 12'h341, 32'h304, 1, 0, 0); tick();
        chk("b2b_mcause2", 1, 12'h342, 32'h3, 1, 0, 0); tick();
        chk("b2b_ms2", 1, 12'h300, 32'h1880, 1, 0, 0); tick();
        chk("b2b_jump2", 0, 0, 0, 1, 1, 32'h400); tick();
        chk("b2b_irq_acc", 0, 0, 0, 1, 0, 0); tick(); irq_ext = 0;
        chk("b2b_mepc3", 1, 12'h341, 32'h304, 1, 0, 0); tick();
        chk("b2b_mcause3", 1, 12'h342, 32'h8000_000B, 1, 0, 0); tick();
        chk("b2b_ms3", 1, 12'h300, 32'h1880, 1, 0, 0); tick();
        chk("b2b_jump3", 0, 0, 0, 1, 1, 32'h400); tick();
        chk("b2b_idle", 0, 0, 0, 0, 0, 0);

        // randomized run against the script-queue model
        do_reset();
        script.delete();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] r;
            exc_valid  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 2))
                0: exc_cause = 4'd2;
                1: exc_cause = 4'd3;
                default: exc_cause = 4'd11;
            endcase
            mret_valid = ($urandom_range(0, 7) == 0);
            irq_ext    = ($urandom_range(0, 5) == 0);
            irq_timer  = ($urandom_range(0, 5) == 0);
            ex_pc = $urandom; csr_mstatus = $urandom; csr_mie = $urandom; csr_mepc = $urandom;
            r = $urandom;
            csr_mtvec = {r[31:2], 1'b0, r[0]};
            ex_csr_we = $urandom_range(0, 1); ex_csr_waddr = 12'($urandom); ex_csr_wdata = $urandom;
            @(negedge clk);
            model_check("random");
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer for the RV32 core.
- Takes synchronous exceptions, timer/external interrupts and `mret` from the execute stage, and stalls the pipeline while it runs.
- Writes mepc, mcause and mstatus through the CSR register file's single write port, then flushes and redirects the PC.
- Arbitrates that write port between itself and the execute stage's normal CSR instructions.

Parameters:
- DATA_W, 32, data/CSR width.
- CSR_AW, 12, CSR address width.
- RESET_PC_UNUSED, 0, reserved; must stay 0.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- ex_pc  in  DATA_W  PC of the instruction currently in execute.
- exc_valid  in  1  synchronous exception from execute.
- exc_cause  in  4  exception code (2 illegal, 3 ebreak, 11 ecall-M).
- mret_valid  in  1  execute holds an `mret`.
- irq_ext  in  1  external interrupt, level.
- irq_timer  in  1  timer interrupt, level.
- csr_mstatus  in  DATA_W  current mstatus.
- csr_mie  in  DATA_W  current mie.
- csr_mtvec  in  DATA_W  current mtvec.
- csr_mepc  in  DATA_W  current mepc.
- ex_csr_we  in  1  execute-stage CSR write enable.
- ex_csr_waddr  in  CSR_AW  execute-stage CSR write address.
- ex_csr_wdata  in  DATA_W  execute-stage CSR write data.
- csr_we  out  1  arbitrated write enable to the CSR file.
- csr_waddr  out  CSR_AW  arbitrated write address.
- csr_wdata  out  DATA_W  arbitrated write data.
- stall  out  1  hold the pipeline.
- flush  out  1  kill IF/ID/EX contents.
- redirect_pc  out  DATA_W  new fetch PC, valid when flush=1.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal latches (cause, epc, mstatus) cleared. A reset asserted mid-sequence aborts immediately; partially written CSRs are not rolled back.
- FSM states: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, R_MSTATUS, JUMP.
- Accept in IDLE, combinational, priority order:
  - exc_valid;
  - else irq_ext with mstatus[3] and mie[11];
  - else irq_timer with mstatus[3] and mie[7];
  - else mret_valid.
- Trap accept, same cycle:
  - stall=1; ex_csr_we suppressed (csr_we=0).
  - Latch epc=ex_pc and mstatus=csr_mstatus.
  - Latch cause: {0,exc_cause} for exceptions; 0x8000000B for external; 0x80000007 for timer.
  - Next state W_MEPC.
- Trap sequence, one CSR write per cycle, stall=1 throughout:
  - W_MEPC: write 0x341 with {epc[31:2],2'b00}.
  - W_MCAUSE: write 0x342 with cause.
  - W_MSTATUS: write 0x300 with the latched mstatus changed as MPIE(bit7)=MIE(bit3), MIE=0, MPP[12:11]=2'b11, all other bits unchanged.
  - JUMP.
- mret accept: stall=1, latch mstatus, next state R_MSTATUS.
  - R_MSTATUS: write 0x300 with MIE=MPIE, MPIE=1, MPP=2'b11; go to JUMP.
- JUMP: one cycle; flush=1; stall=1; csr_we=0; redirect_pc is:
  - trap, mtvec[1:0]==2'b01 and cause[31]=1: {mtvec[31:2],2'b00} + (cause[3:0]<<2), 32-bit wrap;
  - other traps: {mtvec[31:2],2'b00};
  - mret: csr_mepc, sampled in JUMP, which already reflects any W_MEPC write.
  - Next state IDLE.
- Latency: trap accept to flush is 4 cycles (accept, W_MEPC, W_MCAUSE, W_MSTATUS, flush in cycle 5); mret accept to flush is 2 cycles.
- Arbitration:
  - IDLE with no accept: csr_we/waddr/wdata = ex_csr_* passthrough, zero added latency (combinational).
  - Any other state: the controller owns the port; ex_csr_* ignored. Execute holds its request because stall=1.
- Sources arriving while not IDLE are ignored; interrupts are level-held and re-evaluated in IDLE.
- An exception on the cycle after JUMP is accepted normally (back-to-back).
- csr_waddr is 0 whenever csr_we=0.

Decomposition:
- Shared package/defines, beside the existing defines:
  - CSR addresses MSTATUS=0x300, MIE=0x304, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342;
  - bit indices MIE=3, MPIE=7, MPP=12:11;
  - cause codes;
  - FSM state encoding (3 bits).
- Sub-modules: none. Interrupt priority plus cause encode is a small combinational block kept inline.

Test Plan:
- ecall: ex_pc=0x00000124, exc_cause=11, mtvec=0x00000200, mstatus=0x00000008 -> writes in order mepc=0x124, mcause=0x0000000B, mstatus=0x00001880; flush with redirect_pc=0x200 on cycle 5; stall high cycles 1-5.
- Vectored timer: mtvec=0x00000201, mie=0x80, mstatus.MIE=1, irq_timer=1 -> mcause=0x80000007, redirect_pc=0x21C. With mstatus.MIE=0: no accept, passthrough continues.
- mret: mstatus=0x00001880, mepc=0x128 -> write mstatus=0x00001888 (MIE=1, MPIE=1, MPP=11); redirect_pc=0x128 on cycle 3.
- Simultaneous events: exc_valid with irq_ext (both enabled) -> exception cause taken. ex_csr_we=1 on the accept cycle -> csr_we=0. Passthrough in IDLE: ex write 0x305 <= 0xDEAD0000 appears on the csr_* outputs the same cycle.
- Reset in W_MCAUSE: assert rst -> all outputs 0 immediately (asynchronously). After release: IDLE, stall=0.
- Back-to-back: exception held for the cycle after JUMP -> second sequence starts with no idle gap; irq during the sequence is ignored until IDLE.
